cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//  Execute-stage condition unit of the pipelined ARM core. Consumes the NZCV vector
//  produced each cycle by the ALU flag logic and holds the architectural flags register.
//  Evaluates the instruction's 4-bit condition field against the registered flags.
//  Gates the write/branch controls of the instruction in EX and counts squashed instructions.
// PARAMETERS
//  PERF_W     16       width of the saturating condition-fail counter
//  RST_FLAGS  4'b0000  reset value of the flags register, {N,Z,C,V}
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high
//  valid_e      in   1       EX holds a real instruction (0 = bubble)
//  stall_e      in   1       EX frozen this cycle
//  flush_e      in   1       EX instruction squashed this cycle
//  cond_e       in   4       instruction condition field [31:28]
//  flag_w_e     in   2       [1]=update N,Z  [0]=update C,V (S-bit decode)
//  alu_flags    in   4       {N,Z,C,V} from the ALU flag stage, same cycle
//  pcs_e        in   1       ungated PC-source request
//  reg_w_e      in   1       ungated register-write request
//  mem_w_e      in   1       ungated memory-write request
//  perf_clr     in   1       clear the fail counter
//  cond_ex      out  1       condition passed for the EX instruction
//  pcs_g        out  1       pcs_e & cond_ex & valid_e & ~flush_e
//  reg_w_g      out  1       same gating as pcs_g
//  mem_w_g      out  1       same gating as pcs_g
//  flags_q      out  4       registered architectural flags {N,Z,C,V}
//  fail_cnt     out  PERF_W  number of valid instructions squashed by a failed condition
// BEHAVIOUR
//  - Reset (sync): flags_q=RST_FLAGS, fail_cnt=0. Gated outputs are combinational.
//    During reset they follow the inputs against RST_FLAGS.
//  - cond_ex is combinational from cond_e and flags_q (0-cycle latency).
//    flags_q is never bypassed from alu_flags.
//  - Condition table:
//    EQ 0000 Z          NE 0001 ~Z        CS 0010 C         CC 0011 ~C
//    MI 0100 N          PL 0101 ~N        VS 0110 V         VC 0111 ~V
//    HI 1000 C&~Z       LS 1001 ~C|Z      GE 1010 N==V      LT 1011 N!=V
//    GT 1100 ~Z&(N==V)  LE 1101 Z|(N!=V)  AL 1110 1         1111 -> 1 (treated as AL)
//  - Flag write enable: we = valid_e & cond_ex & ~stall_e & ~flush_e.
//    - On the clock edge: if we & flag_w_e[1], flags_q[3:2] <= alu_flags[3:2].
//    - On the clock edge: if we & flag_w_e[0], flags_q[1:0] <= alu_flags[1:0].
//    - Bits not enabled hold their value.
//  - New flags are visible to cond_ex of the next instruction one cycle later.
//    A back-to-back CMP;BEQ sequence therefore needs no stall.
//  - stall_e=1: flags_q and fail_cnt hold. Gated outputs still reflect current inputs;
//    the downstream pipeline register ignores them.
//  - flush_e=1 or valid_e=0: all gated outputs are 0, no flag write, no count.
//    flush_e has priority over stall_e.
//  - Counter increments when valid_e & ~cond_ex & ~stall_e & ~flush_e.
//    - It saturates at 2^PERF_W-1 (no wrap).
//    - perf_clr has priority over increment; fail_cnt=0 on the next edge.
//  - reset asserted mid-stream discards any pending flag write in the same cycle.
// STRUCTURE
//  - Package arm_cond_pkg:
//    - cond_t enum (EQ..AL, NV=4'b1111)
//    - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//    - flag_w_t for the 2-bit write-enable field
//  - Sub-module cond_check: purely combinational (cond_t, flags) -> pass.
//    It is reused later by the decode-stage branch predictor.
//  - Top level holds the flags register, the gating logic and the saturating counter.
// TESTING
//  1. reset, then cond_e=EQ, reg_w_e=1 -> flags_q=0000, cond_ex=0, reg_w_g=0.
//     cond_e=NE -> reg_w_g=1.
//  2. flag_w_e=11, alu_flags=0100, valid, AL -> next cycle flags_q=0100.
//     BEQ with pcs_e=1 -> pcs_g=1.
//  3. flags_q=1111, flag_w_e=10, alu_flags=0000 -> flags_q=0011 (C,V held).
//  4. Sweep all 16 cond_e over all 16 flag values -> cond_ex matches the table (256 checks).
//  5. Failing instruction with stall_e=1 for 3 cycles, then released -> fail_cnt +1 exactly once.
//     Same with flush_e=1 -> no count, no flag write.
//  6. PERF_W=4, 20 failing instructions -> fail_cnt=15.
//     perf_clr together with a fail -> fail_cnt=0.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// ---------------------------------------------------------------------------
// Package arm_cond_pkg
// Shared types for the ARM condition logic: the 4-bit condition field
// encoding, the bit positions of N/Z/C/V inside the flags vector, and the
// 2-bit flag write-enable field produced by the S-bit decode.
// Imported by cond_check (execute and decode stage) and cond_unit.
// ---------------------------------------------------------------------------
package arm_cond_pkg;

   // Condition field [31:28]; 4'b1111 is executed as "always" on this core.
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   // Bit positions inside the {N,Z,C,V} flags vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // nz selects an update of N and Z, cv an update of C and V.
   typedef struct packed {
      logic nz;
      logic cv;
   } flag_w_t;

endpackage

// File: rtl/cond_unit_cond_check.sv
// ---------------------------------------------------------------------------
// Module cond_check
// Purely combinational condition evaluator: decides whether an instruction
// with condition field cond_i executes given the flags {N,Z,C,V}.
// Shared between the execute-stage condition unit and the decode-stage
// branch predictor, so it must stay free of any state.
// Ports:
//   cond_i   in   cond_t  instruction condition field
//   flags_i  in   4       flags {N,Z,C,V}
//   pass_o   out  1       1 when the instruction executes
// ---------------------------------------------------------------------------
module cond_check
   import arm_cond_pkg::*;
(
   input  cond_t       cond_i,
   input  logic [3:0]  flags_i,
   output logic        pass_o
);

   logic flagN;
   logic flagZ;
   logic flagC;
   logic flagV;

   assign flagN = flags_i[FLAG_N];
   assign flagZ = flags_i[FLAG_Z];
   assign flagC = flags_i[FLAG_C];
   assign flagV = flags_i[FLAG_V];

   // AL and the legacy NV encoding both execute unconditionally.
   always_comb begin
      pass_o = 1'b1;
      case (cond_i)
         COND_EQ: pass_o = flagZ;
         COND_NE: pass_o = ~flagZ;
         COND_CS: pass_o = flagC;
         COND_CC: pass_o = ~flagC;
         COND_MI: pass_o = flagN;
         COND_PL: pass_o = ~flagN;
         COND_VS: pass_o = flagV;
         COND_VC: pass_o = ~flagV;
         COND_HI: pass_o = flagC & ~flagZ;
         COND_LS: pass_o = ~flagC | flagZ;
         COND_GE: pass_o = (flagN == flagV);
         COND_LT: pass_o = (flagN != flagV);
         COND_GT: pass_o = ~flagZ & (flagN == flagV);
         COND_LE: pass_o = flagZ | (flagN != flagV);
         default: pass_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// Module cond_unit
// Execute-stage condition unit. Holds the architectural flags register,
// evaluates the EX instruction's condition against it, gates the
// PC-source / register-write / memory-write requests and counts valid
// instructions squashed by a failed condition (saturating).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_e, stall_e,     EX occupancy / freeze / squash
//   flush_e
//   cond_e, flag_w_e,     condition field, S-bit flag update selects,
//   alu_flags             ALU {N,Z,C,V} for this cycle
//   pcs_e, reg_w_e,       ungated write/branch requests
//   mem_w_e
//   perf_clr              clear the fail counter
//   cond_ex               condition passed (combinational)
//   pcs_g, reg_w_g,       gated requests
//   mem_w_g
//   flags_q               registered flags {N,Z,C,V}
//   fail_cnt              saturating count of condition-failed instructions
// ---------------------------------------------------------------------------
module cond_unit
   import arm_cond_pkg::*;
#(
   parameter int         PERF_W    = 16,
   parameter logic [3:0] RST_FLAGS = 4'b0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_e,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic [3:0]        cond_e,
   input  logic [1:0]        flag_w_e,
   input  logic [3:0]        alu_flags,
   input  logic              pcs_e,
   input  logic              reg_w_e,
   input  logic              mem_w_e,
   input  logic              perf_clr,
   output logic              cond_ex,
   output logic              pcs_g,
   output logic              reg_w_g,
   output logic              mem_w_g,
   output logic [3:0]        flags_q,
   output logic [PERF_W-1:0] fail_cnt
);

   flag_w_t           flagW;
   logic              gateOpen;
   logic              advance;
   logic              flagWe;
   logic              failInc;
   logic [3:0]        flags_d;
   logic [PERF_W-1:0] failCnt_q;
   logic [PERF_W-1:0] failCnt_d;

   assign flagW = flag_w_e;

   // The condition always looks at the registered flags, never at
   // alu_flags, so a flag-setting instruction affects only its successors.
   cond_check u_condCheck (
      .cond_i  (cond_t'(cond_e)),
      .flags_i (flags_q),
      .pass_o  (cond_ex)
   );

   // Gated requests ignore stall_e: the downstream pipeline register
   // simply does not capture them while EX is frozen.
   assign gateOpen = cond_ex & valid_e & ~flush_e;
   assign pcs_g    = pcs_e   & gateOpen;
   assign reg_w_g  = reg_w_e & gateOpen;
   assign mem_w_g  = mem_w_e & gateOpen;

   // An instruction retires out of EX only when real, not frozen and not
   // squashed; only then may it touch flags or the counter.
   assign advance = valid_e & ~stall_e & ~flush_e;
   assign flagWe  = advance & cond_ex;
   assign failInc = advance & ~cond_ex;

   // N/Z and C/V are updated independently so that logical ops with S=1
   // can leave C/V untouched.
   always_comb begin
      flags_d = flags_q;
      if (flagWe && flagW.nz) begin
         flags_d[FLAG_N] = alu_flags[FLAG_N];
         flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flagWe && flagW.cv) begin
         flags_d[FLAG_C] = alu_flags[FLAG_C];
         flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
   end

   // Clear wins over increment; the counter sticks at all-ones.
   always_comb begin
      failCnt_d = failCnt_q;
      if (perf_clr) begin
         failCnt_d = '0;
      end else if (failInc && !(&failCnt_q)) begin
         failCnt_d = failCnt_q + PERF_W'(1);
      end
   end

   // Reset takes precedence so a flag write in the reset cycle is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= RST_FLAGS;
         failCnt_q <= '0;
      end else begin
         flags_q   <= flags_d;
         failCnt_q <= failCnt_d;
      end
   end

   assign fail_cnt = failCnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_unit
// Self-checking bench for cond_unit (PERF_W=4 so saturation is reachable).
// A behavioural model tracks the flags and the fail count from the
// condition table and pipeline rules; every cycle the combinational
// outputs and the registered state are compared against it.
// ---------------------------------------------------------------------------
module tb_cond_unit;

   localparam int PW   = 4;
   localparam int CMAX = (1 << PW) - 1;

   logic          clk;
   logic          reset;
   logic          valid_e;
   logic          stall_e;
   logic          flush_e;
   logic [3:0]    cond_e;
   logic [1:0]    flag_w_e;
   logic [3:0]    alu_flags;
   logic          pcs_e;
   logic          reg_w_e;
   logic          mem_w_e;
   logic          perf_clr;
   logic          cond_ex;
   logic          pcs_g;
   logic          reg_w_g;
   logic          mem_w_g;
   logic [3:0]    flags_q;
   logic [PW-1:0] fail_cnt;

   int            errCount;
   int            checkCount;
   logic [3:0]    mFlags;
   int            mCnt;

   cond_unit #(.PERF_W(PW), .RST_FLAGS(4'b0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_e   (valid_e),
      .stall_e   (stall_e),
      .flush_e   (flush_e),
      .cond_e    (cond_e),
      .flag_w_e  (flag_w_e),
      .alu_flags (alu_flags),
      .pcs_e     (pcs_e),
      .reg_w_e   (reg_w_e),
      .mem_w_e   (mem_w_e),
      .perf_clr  (perf_clr),
      .cond_ex   (cond_ex),
      .pcs_g     (pcs_g),
      .reg_w_g   (reg_w_g),
      .mem_w_g   (mem_w_g),
      .flags_q   (flags_q),
      .fail_cnt  (fail_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Condition table, evaluated on separate flag booleans.
   function automatic logic modelPass(input logic [3:0] c, input logic [3:0] f);
      logic n;
      logic z;
      logic cf;
      logic v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return cf;
         4'd3:    return !cf;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return cf && !z;
         4'd9:    return !cf || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic driveInputs(input logic v, input logic s, input logic f,
                              input logic [3:0] c, input logic [1:0] fw,
                              input logic [3:0] alu, input logic p,
                              input logic rw, input logic mw, input logic clr);
      valid_e   = v;
      stall_e   = s;
      flush_e   = f;
      cond_e    = c;
      flag_w_e  = fw;
      alu_flags = alu;
      pcs_e     = p;
      reg_w_e   = rw;
      mem_w_e   = mw;
      perf_clr  = clr;
   endtask

   // One cycle: check combinational outputs against the model, clock,
   // advance the model, then check the registered state.
   task automatic applyStimulus(input string tag);
      logic pass;
      logic gate;
      logic moves;
      #1;
      pass = modelPass(cond_e, mFlags);
      gate = pass && valid_e && !flush_e;
      checkOutput({tag, ".cond_ex"}, 32'(cond_ex), 32'(pass));
      checkOutput({tag, ".pcs_g"},   32'(pcs_g),   32'(pcs_e && gate));
      checkOutput({tag, ".reg_w_g"}, 32'(reg_w_g), 32'(reg_w_e && gate));
      checkOutput({tag, ".mem_w_g"}, 32'(mem_w_g), 32'(mem_w_e && gate));
      @(posedge clk);
      moves = valid_e && !stall_e && !flush_e;
      if (reset) begin
         mFlags = 4'b0000;
         mCnt   = 0;
      end else begin
         if (moves && pass && flag_w_e[1]) mFlags[3:2] = alu_flags[3:2];
         if (moves && pass && flag_w_e[0]) mFlags[1:0] = alu_flags[1:0];
         if (perf_clr) mCnt = 0;
         else if (moves && !pass && mCnt < CMAX) mCnt = mCnt + 1;
      end
      #1;
      checkOutput({tag, ".flags_q"},  32'(flags_q),  32'(mFlags));
      checkOutput({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(mCnt));
   endtask

   initial begin
      errCount   = 0;
      checkCount = 0;
      mFlags     = 4'b0000;
      mCnt       = 0;
      reset      = 1'b1;
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0001, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      // Reset: state cleared, flag write discarded, gates follow RST_FLAGS.
      applyStimulus("rst");
      checkOutput("rst_flags", 32'(flags_q), 32'd0);
      checkOutput("rst_cnt", 32'(fail_cnt), 32'd0);
      reset = 1'b0;

      // EQ fails on Z=0, NE passes.
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("t1_eq_reg_w_g", 32'(reg_w_g), 32'd0);
      applyStimulus("t1eq");
      checkOutput("t1_eq_cnt", 32'(fail_cnt), 32'd1);
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("t1_ne_reg_w_g", 32'(reg_w_g), 32'd1);
      applyStimulus("t1ne");

      // Flag write then back-to-back BEQ.
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t2cmp");
      checkOutput("t2_flags", 32'(flags_q), 32'h4);
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("t2_beq_pcs_g", 32'(pcs_g), 32'd1);
      applyStimulus("t2beq");

      // Partial update keeps C,V.
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t3set");
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t3nz");
      checkOutput("t3_flags", 32'(flags_q), 32'h3);

      // Full table sweep; valid=0 so nothing changes while sweeping conds.
      for (int f = 0; f < 16; f++) begin
         driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
         applyStimulus("t4set");
         for (int c = 0; c < 16; c++) begin
            driveInputs(1'b0, 1'b0, 1'b0, 4'(c), 2'b11, ~4'(f), 1'b1, 1'b1, 1'b1, 1'b0);
            applyStimulus("t4sweep");
         end
      end

      // Stalled failing instruction counts once on release; flush never.
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("t5clr");
      for (int i = 0; i < 3; i++) begin
         driveInputs(1'b1, 1'b1, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
         applyStimulus("t5stall");
      end
      checkOutput("t5_stall_cnt", 32'(fail_cnt), 32'd0);
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus("t5rel");
      checkOutput("t5_rel_cnt", 32'(fail_cnt), 32'd1);
      driveInputs(1'b1, 1'b1, 1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus("t5flush");
      checkOutput("t5_flush_cnt", 32'(fail_cnt), 32'd1);
      checkOutput("t5_flush_flags", 32'(flags_q), 32'h0);

      // Saturation and clear-over-increment.
      for (int i = 0; i < 20; i++) begin
         driveInputs(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
         applyStimulus("t6fail");
      end
      checkOutput("t6_sat", 32'(fail_cnt), 32'(CMAX));
      driveInputs(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("t6clr");
      checkOutput("t6_clr", 32'(fail_cnt), 32'd0);

      // Mid-stream reset drops a pending flag write.
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t7set");
      reset = 1'b1;
      driveInputs(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus("t7rst");
      checkOutput("t7_flags", 32'(flags_q), 32'h0);
      reset = 1'b0;

      // Random traffic; perf_clr only outside stalls.
      for (int i = 0; i < 400; i++) begin
         logic s;
         s = ($urandom_range(0, 3) == 0);
         driveInputs(($urandom_range(0, 4) != 0), s, ($urandom_range(0, 5) == 0),
                     4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom),
                     !s && ($urandom_range(0, 40) == 0));
         reset = ($urandom_range(0, 100) == 0);
         applyStimulus("rand");
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
